// File: rtl/fwd_operand_mux.sv
// EX-stage operand/forwarding selector with its pipeline register folded in.
// Stall holds the register, flush kills it, and out-of-range selects raise a sticky error.
module fwd_operand_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    localparam int SEL_W     = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         in_valid,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    output logic [SEL_W-1:0]             out_sel,
    output logic                         sel_err
);

    logic signed [DATA_WIDTH-1:0] mux_d;
    logic                         sel_ok;
    logic                         load;
    logic                         err_set;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  err_q, err_d;

    // A power-of-two input count cannot be addressed out of range.
    generate
        if ((1 << SEL_W) == NUM_IN) begin : g_full_range
            assign sel_ok = 1'b1;
        end else begin : g_partial_range
            assign sel_ok = (int'(sel) < NUM_IN);
        end
    endgenerate

    always_comb begin
        mux_d = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                mux_d = in_bus[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign load    = !flush && !stall;
    assign err_set = load && in_valid && !sel_ok;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        sel_d  = sel_q;
        if (flush) begin
            data_d = '0;
            vld_d  = 1'b0;
            sel_d  = '0;
        end else if (!stall) begin
            data_d = mux_d;
            vld_d  = in_valid;
            sel_d  = sel;
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Pipeline register stage boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            sel_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            sel_q  <= sel_d;
            err_q  <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;
    assign out_sel   = sel_q;
    assign sel_err   = err_q;

endmodule

// File: doc/fwd_operand_mux.md
# fwd_operand_mux

Parametrised N-input operand-select stage with an output pipeline register, stall hold, flush and select-range checking. It replaces fixed-width, fixed-arity combinational selectors on the EX-stage operand and forwarding paths. Because of the registered output, selection and the EX pipeline register are one block. Stall and flush come straight from the hazard unit.

## Interface
- DATA_WIDTH, 32, width of each data input and the output (1..64)
- NUM_IN, 4, number of data inputs (2..16); SEL_W = $clog2(NUM_IN), derived, not overridable
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_bus  in  NUM_IN*DATA_WIDTH  flattened inputs; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- sel  in  SEL_W  binary select of the input to capture
- in_valid  in  1  current sel/in_bus carry a real instruction
- stall  in  1  hold the output register
- flush  in  1  kill the output register contents
- err_clr  in  1  clear the sticky select-error flag
- out_data  out  DATA_WIDTH  registered selected data
- out_valid  out  1  out_data belongs to a live instruction
- out_sel  out  SEL_W  registered copy of the sel that produced out_data
- sel_err  out  1  sticky flag: an out-of-range select was captured while valid

## Operation
- Combinational select: mux_d = input[sel] when sel < NUM_IN, else all zeros. mux_d is not visible at a port.
- Out-of-range sel is only possible when NUM_IN is not a power of two. For NUM_IN = 2^k the range check is constant-true and sel_err never sets.
- Output register update at each rising clk, in strict priority:
  1. flush=1: out_data <= 0, out_valid <= 0, out_sel <= 0. Stall is ignored.
  2. stall=1: out_data, out_valid and out_sel all hold.
  3. Otherwise: out_data <= mux_d, out_valid <= in_valid, out_sel <= sel. Data is captured even when in_valid=0; consumers qualify it with out_valid.
- sel_err:
  - Set when a load occurs (case 3) with in_valid=1 and sel >= NUM_IN.
  - Cleared by err_clr=1 when no set condition is present that cycle. Set wins over a simultaneous clear.
  - Not set on flushed or stalled cycles, nor for an invalid sel with in_valid=0.
- No internal state besides out_data, out_valid, out_sel and sel_err.

## Timing
- Reset (asynchronous, active-high), effective immediately and for as long as rst=1: out_data=0, out_valid=0, out_sel=0, sel_err=0.
- First capture is at the first rising clk after rst deasserts.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. There is no combinational path from any input to any output.
- Stall has no length limit. Outputs stay bit-identical across any run of stalled edges, and the first unstalled edge loads the inputs present at that edge.
- flush and stall together at an edge: the flush result wins (zeros, out_valid=0).
- rst asserted mid-stall or mid-flush: outputs go to the reset values asynchronously, and the held value is lost.
- sel changing between edges has no effect; only the value at the edge is used.

## Test plan
- Reset: drive rst=1 with in_bus random, sel=2, in_valid=1, clocks running -> all outputs 0. Deassert rst; after the next edge, out_data=input2, out_valid=1, out_sel=2.
- Sweep (DATA_WIDTH=32, NUM_IN=4): input k = 0xA000_000k, step sel 0..3 one per cycle with in_valid=1 -> out_data equals 0xA000_000k one cycle after sel=k; sel_err stays 0.
- Stall/flush: load sel=1 (0x1111_1111), then hold stall=1 for 3 cycles while sel=3 and the inputs change -> out_data stays 0x1111_1111. Next, assert stall=1 and flush=1 together -> out_data=0, out_valid=0. Next, a plain edge with sel=3 -> input3.
- Range check (NUM_IN=5, SEL_W=3):
  - sel=6, in_valid=1 -> out_data=0, sel_err=1.
  - sel=6, in_valid=0 -> sel_err unchanged.
  - err_clr=1 alone -> sel_err=0.
  - err_clr=1 together with sel=7, in_valid=1 -> sel_err=1.
- Bubble: in_valid=0, sel=0, input0=0xDEAD_BEEF -> out_data=0xDEAD_BEEF, out_valid=0.
- Async reset mid-stall: with out_data=0x5555_5555 held by stall, pulse rst between clock edges -> outputs read 0 before the next edge.
